issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Clocked dual-issue scheduler between fetch and decode. Accepts a 16-bit instruction pair from fetch with a valid/ready handshake and holds it in a two-slot in-order buffer. Each cycle it issues zero, one or two instructions after checking them against a scoreboard of recently issued destinations and against each other. It drives registered issue lanes, a stall flag and a saturating stall counter.

## Interface
- `DEPTH`, 3: hazard window, i.e. the number of past issue cycles tracked per lane (1..7).
- `IW`, 16: instruction width. Field positions below are fixed for IW=16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_valid` in 1: fetch presents a pair.
- `fetch_instr1` in IW: older instruction of the pair.
- `fetch_instr2` in IW: younger instruction of the pair.
- `fetch_ready` out 1: combinational; the pair is accepted on an edge where valid && ready.
- `flush` in 1: synchronous kill of buffered, not-yet-issued instructions.
- `issue_instr1` out IW: registered lane-1 instruction; 0 (nop) when invalid.
- `issue_instr2` out IW: registered lane-2 instruction; 0 when invalid.
- `issue_valid1` out 1: registered.
- `issue_valid2` out 1: registered.
- `single_o` out 1: registered; this cycle issued exactly one instruction and the younger one was held back.
- `stall_o` out 1: registered; this cycle issued nothing while the buffer was non-empty.
- `stall_cnt` out 16: count of stall cycles; saturates at 16'hFFFF.

## Operation
- **Instruction fields**
  - opcode [15:12]; opcode 0 = nop.
  - [11] imm flag: 1 means one source at [7:5]; 0 means sources [7:5] and [4:2].
  - dest [10:8].
- **Buffer states:** EMPTY, SINGLE (slot A only), PAIR (slots A and B). A is always older.
- **Accept**
  - Nop instructions in an accepted pair are dropped.
  - One non-nop instruction goes to A → SINGLE. Two non-nop go to A and B → PAIR. None → stays EMPTY.
- **Scoreboard:** DEPTH×2 entries of {valid, dest}, shifted every edge. Entry [0] is loaded with the lanes issued at that edge; a bubble loads valid=0.
- **RAW(x):** any valid scoreboard entry's dest equals a source of x.
- **Issue decision on each edge, from the registered buffer**
  - A issues iff A is present and !RAW(A).
  - B issues iff A issues, B is present, !RAW(B), and there is no intra-pair hazard. An intra-pair hazard is any of: B reads A.dest; B.dest == A.dest; A reads B.dest.
  - In-order: B never issues without A.
- **Transitions**
  - PAIR, both issue → EMPTY, or directly reload from fetch.
  - PAIR, A only → B moves to A, state SINGLE, single_o=1.
  - PAIR or SINGLE, A blocked → hold, stall_o=1, stall_cnt+1.
  - SINGLE, A issues → EMPTY or reload.
- **fetch_ready** = (state==EMPTY) || (every buffered instruction issues this edge) || flush==0 && … Precisely, it is ready when the buffer will be empty after this edge and flush is low.
- **flush:** at the edge, the buffer → EMPTY, issue outputs → nop/invalid, and the fetch pair is not accepted. The scoreboard keeps shifting, because in-flight instructions remain live.
- **Reset values:** buffer EMPTY, scoreboard all invalid, issue_instr1/2=0, valid1/2=0, single_o=0, stall_o=0, stall_cnt=0. fetch_ready=1 during reset.

## Timing
- Accept at edge N. The earliest issue is edge N+1, with outputs visible after N+1.
- Sustained throughput: 2 instructions per cycle with no hazards (pair accepted on the same edge that the previous one issues).
- A dependent instruction issues exactly DEPTH+1 edges after its producer. stall_o is high for DEPTH cycles in between.
- Outputs change only on clk edges or on rst_n assertion. rst_n deassertion mid-stall restarts from EMPTY.

## Test plan
- **Independent pair.** Reset, then pair (16'h1328, 16'h1528).
  - Next edge: issue_instr1=1328, issue_instr2=1528, both valid, single_o=0, fetch_ready=1.
- **Intra-pair RAW.** Pair (16'h1328, 16'h2460) into an empty scoreboard.
  - Edge 1: lane1=1328, lane2=0, single_o=1.
  - Edges 2–4: stall_o=1.
  - Edge 5: issue_instr1=2460.
  - stall_cnt=3.
- **Cross-cycle RAW.** Pair (1328, 0) followed by pair (2460, 1528).
  - The second pair issues both lanes together exactly DEPTH+1 edges after 1328.
  - fetch_ready stays low until then.
- **Flush.** Flush asserted while 2460 is stalled in SINGLE.
  - Next edge: outputs nop/invalid, state EMPTY, fetch_ready=1.
  - A later independent pair issues normally.
- **Nop handling.** Pair (0, 16'h1528).
  - Next edge: issue_instr1=1528, valid2=0, single_o=0.
  - Pair (0, 0): no issue, stall_o=0.
- **Reset mid-stall.** Assert rst_n=0 during a stall.
  - All outputs go 0 immediately, stall_cnt=0, fetch_ready=1.

Source files
------------

// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: a two-slot buffer between fetch and decode,
// issuing up to two instructions per cycle against a shifting scoreboard of recent destinations.
module issue_scheduler #(
  parameter int DEPTH = 3,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_valid,
  input  logic [IW-1:0] fetch_instr1,
  input  logic [IW-1:0] fetch_instr2,
  output logic          fetch_ready,
  input  logic          flush,
  output logic [IW-1:0] issue_instr1,
  output logic [IW-1:0] issue_instr2,
  output logic          issue_valid1,
  output logic          issue_valid2,
  output logic          single_o,
  output logic          stall_o,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_SINGLE, S_PAIR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] slot_a_q, slot_a_d;
  logic [IW-1:0] slot_b_q, slot_b_d;

  logic          sb_v_q [2*DEPTH];
  logic          sb_v_d [2*DEPTH];
  logic [2:0]    sb_d_q [2*DEPTH];
  logic [2:0]    sb_d_d [2*DEPTH];

  logic [IW-1:0] issue_instr1_q, issue_instr1_d;
  logic [IW-1:0] issue_instr2_q, issue_instr2_d;
  logic          issue_valid1_q, issue_valid1_d;
  logic          issue_valid2_q, issue_valid2_d;
  logic          single_q, single_d;
  logic          stall_q, stall_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic raw_a, raw_b, intra, iss_a, iss_b, will_empty, accept;

  function automatic logic reads(input logic [IW-1:0] ins, input logic [2:0] r);
    return (ins[7:5] == r) || (!ins[11] && (ins[4:2] == r));
  endfunction

  function automatic logic is_nop(input logic [IW-1:0] ins);
    return ins[15:12] == 4'd0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Hazard evaluation and issue decision from the registered buffer.
  always_comb begin
    raw_a = 1'b0;
    raw_b = 1'b0;
    for (int i = 0; i < 2*DEPTH; i++) begin
      if (sb_v_q[i]) begin
        if (reads(slot_a_q, sb_d_q[i])) raw_a = 1'b1;
        if (reads(slot_b_q, sb_d_q[i])) raw_b = 1'b1;
      end
    end
    intra = reads(slot_b_q, slot_a_q[10:8]) ||
            (slot_b_q[10:8] == slot_a_q[10:8]) ||
            reads(slot_a_q, slot_b_q[10:8]);
    iss_a = (state_q != S_EMPTY) && !raw_a;
    iss_b = iss_a && (state_q == S_PAIR) && !raw_b && !intra;
    will_empty = (state_q == S_EMPTY) ||
                 ((state_q == S_SINGLE) && iss_a) ||
                 ((state_q == S_PAIR) && iss_b);
    fetch_ready = will_empty && !flush;
    accept = fetch_valid && fetch_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Buffer slots hold data only; state_q qualifies them.
  always_ff @(posedge clk) begin
    slot_a_q <= slot_a_d;
    slot_b_q <= slot_b_d;
  end

  // Next-state: retire issued slots, then refill from fetch when the buffer drains.
  always_comb begin
    state_d  = state_q;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_PAIR: begin
          if (iss_b) begin
            state_d = S_EMPTY;
          end else if (iss_a) begin
            slot_a_d = slot_b_q;
            state_d  = S_SINGLE;
          end
        end
        S_SINGLE: if (iss_a) state_d = S_EMPTY;
        default:  state_d = S_EMPTY;
      endcase
      if (accept) begin
        if (!is_nop(fetch_instr1) && !is_nop(fetch_instr2)) begin
          slot_a_d = fetch_instr1;
          slot_b_d = fetch_instr2;
          state_d  = S_PAIR;
        end else if (!is_nop(fetch_instr1)) begin
          slot_a_d = fetch_instr1;
          state_d  = S_SINGLE;
        end else if (!is_nop(fetch_instr2)) begin
          slot_a_d = fetch_instr2;
          state_d  = S_SINGLE;
        end
      end
    end
  end

  // Outputs: issue lanes, status flags and the scoreboard shift.
  always_comb begin
    issue_valid1_d = !flush && iss_a;
    issue_valid2_d = !flush && iss_b;
    issue_instr1_d = issue_valid1_d ? slot_a_q : '0;
    issue_instr2_d = issue_valid2_d ? slot_b_q : '0;
    single_d       = !flush && (state_q == S_PAIR) && iss_a && !iss_b;
    stall_d        = !flush && (state_q != S_EMPTY) && !iss_a;
    stall_cnt_d    = stall_d ? sat_inc(stall_cnt_q) : stall_cnt_q;
    sb_v_d[0] = issue_valid1_d;
    sb_d_d[0] = slot_a_q[10:8];
    sb_v_d[1] = issue_valid2_d;
    sb_d_d[1] = slot_b_q[10:8];
    for (int i = 2; i < 2*DEPTH; i++) begin
      sb_v_d[i] = sb_v_q[i-2];
      sb_d_d[i] = sb_d_q[i-2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_instr1_q <= '0;
      issue_instr2_q <= '0;
      issue_valid1_q <= 1'b0;
      issue_valid2_q <= 1'b0;
      single_q       <= 1'b0;
      stall_q        <= 1'b0;
      stall_cnt_q    <= 16'd0;
      for (int i = 0; i < 2*DEPTH; i++) sb_v_q[i] <= 1'b0;
    end else begin
      issue_instr1_q <= issue_instr1_d;
      issue_instr2_q <= issue_instr2_d;
      issue_valid1_q <= issue_valid1_d;
      issue_valid2_q <= issue_valid2_d;
      single_q       <= single_d;
      stall_q        <= stall_d;
      stall_cnt_q    <= stall_cnt_d;
      for (int i = 0; i < 2*DEPTH; i++) sb_v_q[i] <= sb_v_d[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2*DEPTH; i++) sb_d_q[i] <= sb_d_d[i];
  end

  assign issue_instr1 = issue_instr1_q;
  assign issue_instr2 = issue_instr2_q;
  assign issue_valid1 = issue_valid1_q;
  assign issue_valid2 = issue_valid2_q;
  assign single_o     = single_q;
  assign stall_o      = stall_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus random traffic against a queue-based model.
module tb_issue_scheduler;
  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_instr1 = '0, fetch_instr2 = '0;
  logic        fetch_ready;
  logic        flush = 1'b0;
  logic [15:0] issue_instr1, issue_instr2;
  logic        issue_valid1, issue_valid2, single_o, stall_o;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  issue_scheduler #(.DEPTH(DEPTH), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .fetch_instr1(fetch_instr1), .fetch_instr2(fetch_instr2),
    .fetch_ready(fetch_ready), .flush(flush),
    .issue_instr1(issue_instr1), .issue_instr2(issue_instr2),
    .issue_valid1(issue_valid1), .issue_valid2(issue_valid2),
    .single_o(single_o), .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: buffer as a queue, scoreboard as a list of recent issue cycles.
  typedef struct {bit v1; bit [2:0] d1; bit v2; bit [2:0] d2;} rec_t;
  logic [15:0] mbuf[$];
  rec_t        hist[$];
  logic [15:0] e_i1, e_i2;
  bit          e_v1, e_v2, e_single, e_stall;
  int          e_cnt;
  bit          m_a, m_b, m_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_reads(input logic [15:0] x, input logic [2:0] r);
    return (x[7:5] == r) || (x[11] == 1'b0 && x[4:2] == r);
  endfunction

  function automatic bit m_raw(input logic [15:0] x);
    bit hit = 0;
    foreach (hist[k]) begin
      if (hist[k].v1 && m_reads(x, hist[k].d1)) hit = 1;
      if (hist[k].v2 && m_reads(x, hist[k].d2)) hit = 1;
    end
    return hit;
  endfunction

  task automatic model_reset();
    mbuf.delete();
    hist.delete();
    e_i1 = 0; e_i2 = 0; e_v1 = 0; e_v2 = 0; e_single = 0; e_stall = 0; e_cnt = 0;
  endtask

  task automatic model_pre();
    logic [15:0] a, b;
    m_a = 0; m_b = 0;
    if (mbuf.size() >= 1) begin
      a = mbuf[0];
      m_a = !m_raw(a);
      if (mbuf.size() == 2) begin
        b = mbuf[1];
        m_b = m_a && !m_raw(b) && !m_reads(b, a[10:8]) &&
              (b[10:8] != a[10:8]) && !m_reads(a, b[10:8]);
      end
    end
    m_ready = !flush && (mbuf.size() == 0 || (mbuf.size() == 1 && m_a) ||
                         (mbuf.size() == 2 && m_b));
  endtask

  task automatic model_edge();
    rec_t r;
    int n_iss;
    r.v1 = 0; r.v2 = 0; r.d1 = 0; r.d2 = 0;
    if (flush) begin
      e_i1 = 0; e_i2 = 0; e_v1 = 0; e_v2 = 0; e_single = 0; e_stall = 0;
      mbuf.delete();
    end else begin
      e_v1 = m_a; e_v2 = m_b;
      e_i1 = m_a ? mbuf[0] : 16'h0;
      e_i2 = m_b ? mbuf[1] : 16'h0;
      e_single = (mbuf.size() == 2) && m_a && !m_b;
      e_stall  = (mbuf.size() > 0) && !m_a;
      if (e_stall && e_cnt < 65535) e_cnt++;
      r.v1 = m_a; r.v2 = m_b;
      if (m_a) r.d1 = mbuf[0][10:8];
      if (m_b) r.d2 = mbuf[1][10:8];
      n_iss = int'(m_a) + int'(m_b);
      for (int k = 0; k < n_iss; k++) void'(mbuf.pop_front());
      if (fetch_valid && m_ready) begin
        if (fetch_instr1[15:12] != 0) mbuf.push_back(fetch_instr1);
        if (fetch_instr2[15:12] != 0) mbuf.push_back(fetch_instr2);
      end
    end
    hist.push_front(r);
    while (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  task automatic check_outputs(input string t);
    chk({t, ".i1"},     issue_instr1, e_i1);
    chk({t, ".i2"},     issue_instr2, e_i2);
    chk({t, ".v1"},     issue_valid1, e_v1);
    chk({t, ".v2"},     issue_valid2, e_v2);
    chk({t, ".single"}, single_o, e_single);
    chk({t, ".stall"},  stall_o, e_stall);
    chk({t, ".cnt"},    stall_cnt, e_cnt);
  endtask

  // Called at posedge+1; returns at the next posedge+1 with outputs checked.
  task automatic cycle(input logic v, input logic [15:0] i1, input logic [15:0] i2, input logic fl);
    fetch_valid = v; fetch_instr1 = i1; fetch_instr2 = i2; flush = fl;
    #3;
    model_pre();
    chk("ready", fetch_ready, m_ready);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    fetch_valid = 0; flush = 0;
    rst_n = 0;
    model_reset();
    #1;
    check_outputs("rst");
    chk("rst.ready", fetch_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Independent pair
    cycle(1, 16'h1328, 16'h1528, 0);
    cycle(0, 0, 0, 0);
    chk("ind.i1", issue_instr1, 16'h1328);
    chk("ind.i2", issue_instr2, 16'h1528);
    chk("ind.vv", {issue_valid1, issue_valid2, single_o}, 3'b110);
    chk("ind.ready", fetch_ready, 1);

    // Intra-pair RAW, then reset during the stall
    do_reset();
    cycle(1, 16'h1328, 16'h2460, 0);
    cycle(0, 0, 0, 0);
    chk("intra.e1", {issue_instr1, issue_instr2}, {16'h1328, 16'h0});
    chk("intra.single", single_o, 1);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(0, 0, 0, 0);
      chk("intra.stall", stall_o, 1);
    end
    cycle(0, 0, 0, 0);
    chk("intra.e5", issue_instr1, 16'h2460);
    chk("intra.cnt", stall_cnt, 3);

    do_reset();
    cycle(1, 16'h1328, 16'h2460, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("midrst.stall", stall_o, 1);
    do_reset();
    chk("midrst.cnt", stall_cnt, 0);

    // Cross-cycle RAW
    do_reset();
    cycle(1, 16'h1328, 16'h0000, 0);
    cycle(1, 16'h2460, 16'h1528, 0);
    chk("cross.p1", issue_instr1, 16'h1328);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1, 16'h0000, 16'h0000, 0);
      chk("cross.notready", {stall_o, issue_valid1}, 2'b10);
    end
    cycle(1, 16'h0000, 16'h0000, 0);
    chk("cross.both", {issue_instr1, issue_instr2}, {16'h2460, 16'h1528});

    // Flush while stalled in SINGLE
    do_reset();
    cycle(1, 16'h1328, 16'h2460, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("flush.out", {issue_valid1, issue_valid2, issue_instr1}, 18'h0);
    flush = 0; #1;
    chk("flush.ready", fetch_ready, 1);
    cycle(1, 16'h1328, 16'h1528, 0);
    cycle(0, 0, 0, 0);
    chk("flush.after", {issue_instr1, issue_instr2}, {16'h1328, 16'h1528});

    // Nop handling
    do_reset();
    cycle(1, 16'h0000, 16'h1528, 0);
    cycle(1, 16'h0000, 16'h0000, 0);
    chk("nop.i1", issue_instr1, 16'h1528);
    chk("nop.v2s", {issue_valid2, single_o}, 2'b00);
    cycle(0, 0, 0, 0);
    chk("nop.idle", {issue_valid1, stall_o}, 2'b00);

    // Random traffic with small register ranges to provoke hazards
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] r1, r2;
      r1 = {4'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom)};
      r2 = {4'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom)};
      cycle(($urandom_range(0, 9) < 7), r1, r2, ($urandom_range(0, 39) == 0));
      if (n == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
